// File: rtl/chan_arbiter_pkg.sv
// Shared types and helpers for the channel arbiter: FSM state encoding,
// channel-index width helper and the tagged-word layout selector.
package chan_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_SCAN   = 2'd0,
    ST_SEND   = 2'd1,
    ST_SETTLE = 2'd2
  } arb_state_t;

  // Channel index occupies the MSBs of the tagged output word.
  localparam bit TAG_CH_IN_MSB = 1'b1;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chan_arbiter_if.sv
// FIFO-side and sink-side signals of the channel arbiter. The arbiter
// connects through the master modport; FIFOs and sink use the slave modport.
interface chan_arbiter_if
  import chan_arbiter_pkg::*;
#(
  parameter int unsigned CH_NO  = 4,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned CH_W = ch_width(CH_NO);

  logic                     enable;
  logic [CH_NO-1:0]         available;
  logic [DATA_W*CH_NO-1:0]  data_in;
  logic [CH_NO-1:0]         read;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [CH_W-1:0]          cur_ch;

  modport master (
    input  enable, available, data_in, out_ready,
    output read, out_data, out_valid, cur_ch
  );

  modport slave (
    output enable, available, data_in, out_ready,
    input  read, out_data, out_valid, cur_ch
  );

endinterface

// File: rtl/chan_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: returns the first requesting
// index at or after ptr, wrapping modulo CH_NO.
module rr_pick
  import chan_arbiter_pkg::*;
#(
  parameter int unsigned CH_NO = 4,
  parameter int unsigned CH_W  = ch_width(CH_NO)
) (
  input  logic [CH_NO-1:0] req,
  input  logic [CH_W-1:0]  ptr,
  output logic [CH_W-1:0]  gnt_idx,
  output logic             any
);

  int unsigned     idx;
  logic [CH_W-1:0] sel;

  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int unsigned k = 0; k < CH_NO; k++) begin
      // Explicit compare-and-subtract keeps the wrap correct for non-power-of-2 CH_NO.
      idx = 32'(ptr) + k;
      if (idx >= CH_NO) idx = idx - CH_NO;
      sel = idx[CH_W-1:0];
      if (!any && req[sel]) begin
        any     = 1'b1;
        gnt_idx = sel;
      end
    end
  end

endmodule

// File: rtl/chan_arbiter.sv
// Round-robin burst arbiter popping words from CH_NO FWFT FIFOs onto one
// tagged valid/ready sink. Define ARB_STATS_EN to add the words_sent counter.
module chan_arbiter
  import chan_arbiter_pkg::*;
#(
  parameter int unsigned CH_NO     = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic           i_clk,
  input  logic           _rst,
`ifdef ARB_STATS_EN
  input  logic           stats_clr,
  output logic [15:0]    words_sent,
`endif
  chan_arbiter_if.master bus
);

  localparam int unsigned     CH_W      = ch_width(CH_NO);
  localparam int unsigned     BC_W      = $clog2(BURST_MAX + 1);
  localparam logic [BC_W-1:0] BURST_LIM = BC_W'(BURST_MAX);
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(CH_NO - 1);

  arb_state_t        state_q, state_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
  logic [BC_W-1:0]   burst_q, burst_d;
  logic [CH_NO-1:0]  read_q, read_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic [CH_W-1:0]   pick_idx;
  logic              pick_any;
  logic [DATA_W-1:0] head [CH_NO];

  for (genvar k = 0; k < CH_NO; k++) begin : g_head
    assign head[k] = bus.data_in[DATA_W*k +: DATA_W];
  end

  function automatic logic [CH_NO-1:0] onehot(input logic [CH_W-1:0] ch);
    return CH_NO'(1) << ch;
  endfunction

  function automatic logic [DATA_W-1:0] tag_word(input logic [CH_W-1:0] ch,
                                                 input logic [DATA_W-1:0] w);
    if (TAG_CH_IN_MSB) return {ch, w[DATA_W-1-CH_W:0]};
    else               return {w[DATA_W-1:CH_W], ch};
  endfunction

  rr_pick #(
    .CH_NO (CH_NO),
    .CH_W  (CH_W)
  ) u_pick (
    .req     (bus.available),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cur_ch_d    = cur_ch_q;
    burst_d     = burst_q;
    read_d      = '0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_SCAN: begin
        out_valid_d = 1'b0;
        if (bus.enable && pick_any) begin
          cur_ch_d    = pick_idx;
          read_d      = onehot(pick_idx);
          out_data_d  = tag_word(pick_idx, head[pick_idx]);
          out_valid_d = 1'b1;
          burst_d     = BC_W'(1);
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // available has had a cycle to reflect the previous pop by now.
        if (bus.enable && bus.available[cur_ch_q] && (burst_q < BURST_LIM)) begin
          read_d      = onehot(cur_ch_q);
          out_data_d  = tag_word(cur_ch_q, head[cur_ch_q]);
          out_valid_d = 1'b1;
          burst_d     = burst_q + 1'b1;
          state_d     = ST_SEND;
        end else begin
          rr_ptr_d = (cur_ch_q == LAST_CH) ? '0 : cur_ch_q + 1'b1;
          state_d  = ST_SCAN;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge i_clk or negedge _rst) begin
    if (!_rst) begin
      state_q     <= ST_SCAN;
      rr_ptr_q    <= '0;
      cur_ch_q    <= '0;
      burst_q     <= '0;
      read_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_ch_q    <= cur_ch_d;
      burst_q     <= burst_d;
      read_q      <= read_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.read      = read_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cur_ch    = cur_ch_q;

`ifdef ARB_STATS_EN
  always_ff @(posedge i_clk or negedge _rst) begin
    if (!_rst) begin
      words_sent <= '0;
    end else if (stats_clr) begin
      words_sent <= '0;
    end else if (out_valid_q && bus.out_ready && (words_sent != '1)) begin
      words_sent <= words_sent + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_chan_arbiter.sv
// Scoreboard bench for chan_arbiter: a FIFO model feeds the channels,
// expected tagged words are queued at stimulus time and checked on accept.
module tb_chan_arbiter;

  localparam int unsigned CH_NO     = 4;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BURST_MAX = 2;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] word;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  chan_arbiter_if #(.CH_NO(CH_NO), .DATA_W(DATA_W)) bus ();

`ifdef ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] words_sent;
`endif

  chan_arbiter #(
    .CH_NO     (CH_NO),
    .DATA_W    (DATA_W),
    .BURST_MAX (BURST_MAX)
  ) dut (
    .i_clk      (clk),
    ._rst       (rst_n),
`ifdef ARB_STATS_EN
    .stats_clr  (stats_clr),
    .words_sent (words_sent),
`endif
    .bus        (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] fifo_q [CH_NO][$];
  exp_t        exp_q[$];
  bit          prev_hold = 1'b0;

  function automatic logic [31:0] tag(input logic [1:0] c, input logic [31:0] w);
    return {c, w[29:0]};
  endfunction

  // FIFO model: pop on read, present head words first-word-fall-through.
  always @(negedge clk) begin
    if (bus.read != '0) begin
      n_checks++;
      if (!$onehot(bus.read) || prev_hold) begin
        n_fail++;
        $display("FAIL read_invariant got read=%b hold=%0d required onehot with hold=0", bus.read, prev_hold);
      end
    end
    for (int k = 0; k < CH_NO; k++)
      if (bus.read[k] && fifo_q[k].size() > 0) void'(fifo_q[k].pop_front());
    for (int k = 0; k < CH_NO; k++) begin
      bus.available[k]          = (fifo_q[k].size() != 0);
      bus.data_in[32*k +: 32]   = (fifo_q[k].size() != 0) ? fifo_q[k][0] : 32'h0;
    end
    prev_hold = rst_n && bus.out_valid && !bus.out_ready;
  end

  // Scoreboard: every accepted word must match the head of exp_q.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected got ch=%0d data=%h required no word", bus.cur_ch, bus.out_data);
      end else begin
        e = exp_q.pop_front();
        if (bus.out_data !== tag(e.ch, e.word) || bus.cur_ch !== e.ch) begin
          n_fail++;
          $display("FAIL sb_word got ch=%0d data=%h required ch=%0d data=%h",
                   bus.cur_ch, bus.out_data, e.ch, tag(e.ch, e.word));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid &&
          fifo_q[0].size() == 0 && fifo_q[1].size() == 0 &&
          fifo_q[2].size() == 0 && fifo_q[3].size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_read(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.read != '0) break;
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.enable    = 1'b0;
    bus.out_ready = 1'b0;
`ifdef ARB_STATS_EN
    stats_clr     = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.read !== 4'b0000) begin n_fail++; $display("FAIL reset_read got %b required 0000", bus.read); end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b required 0", bus.out_valid); end
    n_checks++;
    if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h required 0", bus.out_data); end
    n_checks++;
    if (bus.cur_ch !== 2'd0) begin n_fail++; $display("FAIL reset_cur_ch got %0d required 0", bus.cur_ch); end
    rst_n      = 1'b1;
    bus.enable = 1'b1;
    step();
  endtask

  task automatic test_single();
    bit ok;
    bus.out_ready = 1'b1;
    step();
    fifo_q[2].push_back(32'hDEADBEEF);
    exp_q.push_back('{ch: 2'd2, word: 32'hDEADBEEF});
    wait_read(20);
    n_checks++;
    if (bus.read !== 4'b0100) begin n_fail++; $display("FAIL single_read got %b required 0100", bus.read); end
    n_checks++;
    if (bus.out_data !== 32'h9EADBEEF) begin n_fail++; $display("FAIL single_tag got %h required 9eadbeef", bus.out_data); end
    @(negedge clk);
    n_checks++;
    if (bus.read !== 4'b0000) begin n_fail++; $display("FAIL single_read_width got %b required 0000", bus.read); end
    drain(50, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_drain got timeout required drained"); end
    n_checks++;
    if (bus.cur_ch !== 2'd2) begin n_fail++; $display("FAIL single_cur_ch got %0d required 2", bus.cur_ch); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int unsigned ord_ch [12] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 1, 2, 3};
    int unsigned ord_w  [12] = '{0, 1, 0, 1, 0, 1, 0, 1, 2, 2, 2, 2};
    // restart with rr_ptr = 0
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int w = 0; w < 3; w++)
      for (int c = 0; c < CH_NO; c++)
        fifo_q[c].push_back(32'hC0DE0000 + 32'(c * 16 + w));
    for (int i = 0; i < 12; i++)
      exp_q.push_back('{ch: 2'(ord_ch[i]), word: 32'hC0DE0000 + 32'(ord_ch[i] * 16 + ord_w[i])});
    drain(400, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rr_drain got timeout with %0d words pending required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bus.out_ready = 1'b0;
    step();
    fifo_q[1].push_back(32'h11111111);
    fifo_q[1].push_back(32'h22222222);
    exp_q.push_back('{ch: 2'd1, word: 32'h11111111});
    exp_q.push_back('{ch: 2'd1, word: 32'h22222222});
    wait_valid(30, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bp_valid got timeout required out_valid"); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_data !== tag(2'd1, 32'h11111111) || bus.out_valid !== 1'b1 || bus.read !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_hold got data=%h valid=%b read=%b required data=%h valid=1 read=0000",
                 bus.out_data, bus.out_valid, bus.read, tag(2'd1, 32'h11111111));
      end
    end
    step();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_settle got valid=%b required 0", bus.out_valid); end
    drain(50, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bp_drain got timeout required drained"); end
  endtask

  task automatic test_wrap();
    bit ok;
    step();
    fifo_q[3].push_back(32'h33333333);
    exp_q.push_back('{ch: 2'd3, word: 32'h33333333});
    drain(50, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL wrap_drain1 got timeout required drained"); end
    step();
    fifo_q[0].push_back(32'h00000A0A);
    fifo_q[3].push_back(32'h3333B0B0);
    exp_q.push_back('{ch: 2'd0, word: 32'h00000A0A});
    exp_q.push_back('{ch: 2'd3, word: 32'h3333B0B0});
    wait_read(20);
    n_checks++;
    if (bus.read !== 4'b0001) begin n_fail++; $display("FAIL wrap_first got read=%b required 0001", bus.read); end
    drain(50, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL wrap_drain2 got timeout required drained"); end
  endtask

  task automatic test_enable();
    bit ok;
    bus.out_ready = 1'b0;
    step();
    fifo_q[1].push_back(32'h0000E001);
    fifo_q[1].push_back(32'h0000E002);
    fifo_q[1].push_back(32'h0000E003);
    exp_q.push_back('{ch: 2'd1, word: 32'h0000E001});
    wait_valid(30, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL en_valid got timeout required out_valid"); end
    step();
    bus.enable    = 1'b0;
    bus.out_ready = 1'b1;
    fifo_q[0].push_back(32'h0000D000);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.read !== 4'b0000) begin n_fail++; $display("FAIL en_no_read got %b required 0000", bus.read); end
    end
    n_checks++;
    if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL en_inflight got pending=%0d valid=%b required pending=0 valid=0", exp_q.size(), bus.out_valid);
    end
    // rr_ptr moved past ch1, so ch0 is served before ch1 resumes
    exp_q.push_back('{ch: 2'd0, word: 32'h0000D000});
    exp_q.push_back('{ch: 2'd1, word: 32'h0000E002});
    exp_q.push_back('{ch: 2'd1, word: 32'h0000E003});
    step();
    bus.enable = 1'b1;
    drain(100, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL en_resume got timeout required drained"); end
  endtask

  task automatic test_async_reset();
    bit ok;
    bus.out_ready = 1'b0;
    step();
    fifo_q[2].push_back(32'h2222C0C0);
    wait_valid(30, ok);
    n_checks++;
    if (!ok || bus.read !== 4'b0100) begin
      n_fail++;
      $display("FAIL ar_setup got valid=%b read=%b required valid=1 read=0100", bus.out_valid, bus.read);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.read !== 4'b0000 || bus.cur_ch !== 2'd0) begin
      n_fail++;
      $display("FAIL ar_drop got valid=%b read=%b cur_ch=%0d required valid=0 read=0000 cur_ch=0",
               bus.out_valid, bus.read, bus.cur_ch);
    end
`ifdef ARB_STATS_EN
    n_checks++;
    if (words_sent !== 16'd0) begin n_fail++; $display("FAIL ar_stats got %0d required 0", words_sent); end
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_idle got valid=%b required 0", bus.out_valid); end
    end
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    bit ok;
    step();
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    n_checks++;
    if (words_sent !== 16'd0) begin n_fail++; $display("FAIL stats_clr got %0d required 0", words_sent); end
    for (int w = 0; w < 3; w++) begin
      fifo_q[0].push_back(32'h5000 + 32'(w));
      exp_q.push_back('{ch: 2'd0, word: 32'h5000 + 32'(w)});
    end
    drain(100, ok);
    n_checks++;
    if (!ok || words_sent !== 16'd3) begin n_fail++; $display("FAIL stats_count got %0d required 3", words_sent); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_enable();
    test_async_reset();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_leftover got %0d required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
